fht_stream_ctrl: RTL and testbench
==================================

Name: fht_stream_ctrl

Overview:
- Stream-side driver for the 4-bank FHT core.
- Accepts a serial sample stream with valid/ready and scatters each frame of N = 4*2^A_BIT points into the core's four RAM banks via the bank-select write port. It then pulses start and waits for the core's ready.
- After ready, it reads the four banks back in parallel and re-serialises the transformed frame onto an output valid/ready stream with an end-of-frame marker.

Parameters:
D_BIT, 16, sample width (matches core data width)
A_BIT, 8, per-bank address width; frame length N = 4*2^A_BIT

Ports:
iCLK  in  1  clock
iRESET  in  1  asynchronous active-low reset
iS_VALID  in  1  input sample valid
iS_DATA  in  D_BIT  input sample (signed)
oS_READY  out  1  controller accepts input sample
oM_VALID  out  1  output sample valid
oM_DATA  out  D_BIT  output sample (signed)
oM_LAST  out  1  marks last sample of output frame
iM_READY  in  1  downstream accepts output sample
oWE  out  4  one-hot bank write enable to core
oDATA_0..oDATA_3  out  D_BIT each  write data to core banks 0..3
oADDR_WR_0..oADDR_WR_3  out  A_BIT each  write address to banks 0..3
oADDR_RD_0..oADDR_RD_3  out  A_BIT each  read address to banks 0..3
iDATA_0..iDATA_3  in  D_BIT each  read data from banks 0..3 (1-cycle read latency)
oSTART  out  1  single-cycle start strobe to core
iRDY  in  1  core done (level or pulse; rising edge is used)
oBUSY  out  1  high in every state except LOAD with load count 0

Behaviour:
- Reset (iRESET=0, async): state LOAD, counters 0. All outputs 0 except oS_READY=1.
- Index mapping: point n goes to bank n[1:0] at address n[A_BIT+1:2].
- LOAD:
  - oS_READY=1.
  - On iS_VALID&oS_READY, a registered write is issued the next cycle: oWE = one-hot(n[1:0]). All four oDATA_x carry the sample and all four oADDR_WR_x carry n>>2.
  - oWE=0 on cycles with no accepted sample.
  - After sample N-1 is accepted, oS_READY drops in the same registered update and the state goes to START.
- START: one cycle; oSTART=1; then WAIT.
- WAIT:
  - Keeps a registered copy of iRDY.
  - Goes to READ on the first 0->1 transition of iRDY seen after START; a level already high at START is ignored until it falls.
- READ (address phase): all oADDR_RD_x = k (row counter, starts 0); next state CAP.
- CAP: latches iDATA_0..3 into a 4-entry output buffer; slot index 0; state SEND.
- SEND:
  - oM_VALID=1; oM_DATA = buffer[slot].
  - oM_LAST=1 only when k=2^A_BIT-1 and slot=3.
  - On iM_READY: slot increments.
  - After slot 3: if k is the last row, k=0 and the state goes to LOAD with oS_READY=1 next cycle. Otherwise k increments and the state goes to READ.
  - oM_VALID/oM_DATA/oM_LAST are held stable while iM_READY=0.
- Output order is natural index n = 4k+slot.
- Throughput: 4 samples per 6 cycles under continuous iM_READY.
- oADDR_RD_x and oADDR_WR_x hold their last values outside their active states.
- Reset mid-frame: state and counters return to reset values immediately. The partial frame is discarded and the core is not restarted.
- iS_VALID outside LOAD is ignored (oS_READY=0).
- iM_READY while oM_VALID=0 has no effect.

Optional Feature:
FHT_STREAM_BITREV_EN
- Defined:
  - Output sequence index j maps to n = bitreverse(j) over A_BIT+2 bits.
  - READ drives all oADDR_RD_x = n>>2; CAP latches only iDATA_{n[1:0]}; SEND emits one sample, then goes to READ.
  - Throughput is 1 sample per 3 cycles.
  - oM_LAST=1 on j=N-1.
- Undefined: natural order, 4-wide row readback as above.

Test Plan (A_BIT=2, N=16, D_BIT=16):
- Load samples 0..15 with iS_VALID held high -> oWE sequence 0001,0010,0100,1000 repeating; oADDR_WR steps 0,0,0,0,1,...,3. oSTART is pulsed exactly once, 1 cycle after the 16th acceptance is registered.
- After load, hold iRDY=0 for 20 cycles, then pulse it high for 1 cycle -> READ entered the next cycle; oADDR_RD_x=0. Model core returns row words {4k,4k+1,4k+2,4k+3} -> oM_DATA 0..15 in order, oM_LAST only with value 15.
- Toggle iM_READY randomly 50% during SEND -> no sample lost or duplicated; oM_DATA is stable while stalled.
- Hold iRDY high across START -> no READ until iRDY falls and rises again.
- Assert iRESET=0 after 7 loaded samples -> next cycle oWE=0, oSTART=0, oS_READY=1, oBUSY=0. A fresh 16-sample frame then loads from address 0, bank 0.
- With FHT_STREAM_BITREV_EN, natural-order core data 0..15 -> output order 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with oM_LAST on 15.

Source files
------------

// File: rtl/fht_stream_ctrl.sv
// Stream-side driver for the 4-bank FHT core: scatters a serial frame into the banks, starts the core, re-serialises the result.
// Define FHT_STREAM_BITREV_EN for bit-reversed output order, one bank read per sample.
module fht_stream_ctrl #(
  parameter int D_BIT = 16,
  parameter int A_BIT = 8
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic                    iS_VALID,
  input  logic signed [D_BIT-1:0] iS_DATA,
  output logic                    oS_READY,
  output logic                    oM_VALID,
  output logic signed [D_BIT-1:0] oM_DATA,
  output logic                    oM_LAST,
  input  logic                    iM_READY,
  output logic [3:0]              oWE,
  output logic signed [D_BIT-1:0] oDATA_0,
  output logic signed [D_BIT-1:0] oDATA_1,
  output logic signed [D_BIT-1:0] oDATA_2,
  output logic signed [D_BIT-1:0] oDATA_3,
  output logic [A_BIT-1:0]        oADDR_WR_0,
  output logic [A_BIT-1:0]        oADDR_WR_1,
  output logic [A_BIT-1:0]        oADDR_WR_2,
  output logic [A_BIT-1:0]        oADDR_WR_3,
  output logic [A_BIT-1:0]        oADDR_RD_0,
  output logic [A_BIT-1:0]        oADDR_RD_1,
  output logic [A_BIT-1:0]        oADDR_RD_2,
  output logic [A_BIT-1:0]        oADDR_RD_3,
  input  logic signed [D_BIT-1:0] iDATA_0,
  input  logic signed [D_BIT-1:0] iDATA_1,
  input  logic signed [D_BIT-1:0] iDATA_2,
  input  logic signed [D_BIT-1:0] iDATA_3,
  output logic                    oSTART,
  input  logic                    iRDY,
  output logic                    oBUSY
);

  localparam int IW = A_BIT + 2;
  localparam logic [IW-1:0] IDX_LAST = '1;

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_WAIT,
    S_READ,
    S_CAP,
    S_SEND
  } state_t;

  state_t            state, state_n;
  logic [IW-1:0]     load_cnt, load_cnt_n;
  logic [IW-1:0]     idx, idx_n;
  logic [IW-1:0]     rd_pt;
  logic              rdy_q;
  logic              accept;
  logic [3:0]        we;
  logic [D_BIT-1:0]  wr_data;
  logic [A_BIT-1:0]  wr_addr;
  logic [A_BIT-1:0]  rd_addr;

  function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < IW; i++) r[i] = v[IW-1-i];
    return r;
  endfunction

  assign accept = (state == S_LOAD) && iS_VALID;

  // A single output index serves both orders: natural mode splits it into row (idx>>2) and slot (idx[1:0]).
  always_comb begin
    state_n    = state;
    load_cnt_n = load_cnt;
    idx_n      = idx;
    case (state)
      S_LOAD: begin
        if (accept) begin
          load_cnt_n = load_cnt + 1'b1;
          if (load_cnt == IDX_LAST) state_n = S_START;
        end
      end
      S_START: state_n = S_WAIT;
      S_WAIT:  if (iRDY && !rdy_q) state_n = S_READ;
      S_READ:  state_n = S_CAP;
      S_CAP:   state_n = S_SEND;
      S_SEND: begin
        if (iM_READY) begin
          idx_n = idx + 1'b1;
`ifdef FHT_STREAM_BITREV_EN
          state_n = (idx == IDX_LAST) ? S_LOAD : S_READ;
`else
          if (idx[1:0] == 2'b11) state_n = (idx == IDX_LAST) ? S_LOAD : S_READ;
`endif
        end
      end
      default: state_n = S_LOAD;
    endcase
  end

`ifdef FHT_STREAM_BITREV_EN
  assign rd_pt = bitrev(idx_n);
`else
  assign rd_pt = idx_n;
`endif

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state    <= S_LOAD;
      load_cnt <= '0;
      idx      <= '0;
      rdy_q    <= 1'b0;
      we       <= '0;
      wr_data  <= '0;
      wr_addr  <= '0;
      rd_addr  <= '0;
    end else begin
      state    <= state_n;
      load_cnt <= load_cnt_n;
      idx      <= idx_n;
      rdy_q    <= iRDY;
      we       <= accept ? (4'b0001 << load_cnt[1:0]) : 4'b0000;
      if (accept) begin
        wr_data <= iS_DATA;
        wr_addr <= load_cnt[IW-1:2];
      end
      // Address is loaded on entry so the bank sees it during READ and data lands in CAP.
      if (state_n == S_READ) rd_addr <= rd_pt[IW-1:2];
    end
  end

`ifdef FHT_STREAM_BITREV_EN
  logic [D_BIT-1:0] obuf;
  logic [IW-1:0]    cap_pt;

  assign cap_pt = bitrev(idx);

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      obuf <= '0;
    end else if (state == S_CAP) begin
      case (cap_pt[1:0])
        2'd0:    obuf <= iDATA_0;
        2'd1:    obuf <= iDATA_1;
        2'd2:    obuf <= iDATA_2;
        default: obuf <= iDATA_3;
      endcase
    end
  end

  assign oM_DATA = obuf;
`else
  logic [3:0][D_BIT-1:0] obuf;

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      obuf <= '0;
    end else if (state == S_CAP) begin
      obuf <= {iDATA_3, iDATA_2, iDATA_1, iDATA_0};
    end
  end

  assign oM_DATA = obuf[idx[1:0]];
`endif

  assign oS_READY   = (state == S_LOAD);
  assign oSTART     = (state == S_START);
  assign oM_VALID   = (state == S_SEND);
  assign oM_LAST    = (state == S_SEND) && (idx == IDX_LAST);
  assign oBUSY      = !((state == S_LOAD) && (load_cnt == '0));

  assign oWE        = we;
  assign oDATA_0    = wr_data;
  assign oDATA_1    = wr_data;
  assign oDATA_2    = wr_data;
  assign oDATA_3    = wr_data;
  assign oADDR_WR_0 = wr_addr;
  assign oADDR_WR_1 = wr_addr;
  assign oADDR_WR_2 = wr_addr;
  assign oADDR_WR_3 = wr_addr;
  assign oADDR_RD_0 = rd_addr;
  assign oADDR_RD_1 = rd_addr;
  assign oADDR_RD_2 = rd_addr;
  assign oADDR_RD_3 = rd_addr;

endmodule

// File: tb/tb_fht_stream_ctrl.sv
// Directed bench for fht_stream_ctrl with an identity-transform bank model and an output scoreboard.
// Follows FHT_STREAM_BITREV_EN to choose the expected output order.
module tb_fht_stream_ctrl;
  localparam int D = 16;
  localparam int A = 2;
  localparam int N = 16;
`ifdef FHT_STREAM_BITREV_EN
  localparam int THR_CYC = 46;
`else
  localparam int THR_CYC = 22;
`endif

  logic         iCLK = 1'b0;
  logic         iRESET, iS_VALID, iM_READY, iRDY;
  logic [D-1:0] iS_DATA;
  logic         oS_READY, oM_VALID, oM_LAST, oSTART, oBUSY;
  logic [D-1:0] oM_DATA;
  logic [3:0]   oWE;
  logic [D-1:0] oDATA_0, oDATA_1, oDATA_2, oDATA_3;
  logic [A-1:0] oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
  logic [A-1:0] oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3;
  logic [D-1:0] iDATA_0, iDATA_1, iDATA_2, iDATA_3;

  logic [D-1:0] mem [4][4];
  logic [D-1:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0;

  always #5 iCLK = ~iCLK;

  fht_stream_ctrl #(.D_BIT(D), .A_BIT(A)) dut (
    .iCLK(iCLK), .iRESET(iRESET),
    .iS_VALID(iS_VALID), .iS_DATA(iS_DATA), .oS_READY(oS_READY),
    .oM_VALID(oM_VALID), .oM_DATA(oM_DATA), .oM_LAST(oM_LAST), .iM_READY(iM_READY),
    .oWE(oWE),
    .oDATA_0(oDATA_0), .oDATA_1(oDATA_1), .oDATA_2(oDATA_2), .oDATA_3(oDATA_3),
    .oADDR_WR_0(oADDR_WR_0), .oADDR_WR_1(oADDR_WR_1), .oADDR_WR_2(oADDR_WR_2), .oADDR_WR_3(oADDR_WR_3),
    .oADDR_RD_0(oADDR_RD_0), .oADDR_RD_1(oADDR_RD_1), .oADDR_RD_2(oADDR_RD_2), .oADDR_RD_3(oADDR_RD_3),
    .iDATA_0(iDATA_0), .iDATA_1(iDATA_1), .iDATA_2(iDATA_2), .iDATA_3(iDATA_3),
    .oSTART(oSTART), .iRDY(iRDY), .oBUSY(oBUSY)
  );

  // Core stand-in: four banks, identity transform, 1-cycle registered read.
  always @(posedge iCLK) begin
    if (oWE[0]) mem[0][oADDR_WR_0] <= oDATA_0;
    if (oWE[1]) mem[1][oADDR_WR_1] <= oDATA_1;
    if (oWE[2]) mem[2][oADDR_WR_2] <= oDATA_2;
    if (oWE[3]) mem[3][oADDR_WR_3] <= oDATA_3;
    iDATA_0 <= mem[0][oADDR_RD_0];
    iDATA_1 <= mem[1][oADDR_RD_1];
    iDATA_2 <= mem[2][oADDR_RD_2];
    iDATA_3 <= mem[3][oADDR_RD_3];
    if (oSTART) start_cnt <= start_cnt + 1;
  end

  function automatic int bitrev4(input int v);
    logic [3:0] a, r;
    a = v[3:0];
    for (int i = 0; i < 4; i++) r[i] = a[3-i];
    return int'(r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic load_frame(input int nsamp, input logic [D-1:0] base, input bit gap);
    logic [D-1:0] smp [N];
    logic [3:0]   w;
    int           s0;
    int           n;
    s0 = start_cnt;
    for (int i = 0; i < nsamp; i++) begin
      if (gap && i == 5) begin
        iS_VALID = 1'b0;
        tick();
        check("we_idle", oWE, 0);
      end
      smp[i]   = base + D'(i * 37);
      iS_VALID = 1'b1;
      iS_DATA  = smp[i];
      check("s_ready", oS_READY, 1);
      tick();
      w = 4'b0001 << (i % 4);
      check("we_onehot", oWE, w);
      check("addr_wr0", oADDR_WR_0, i / 4);
      check("addr_wr3", oADDR_WR_3, i / 4);
      check("wdata1", oDATA_1, smp[i]);
      check("wdata3", oDATA_3, smp[i]);
    end
    iS_VALID = 1'b0;
    if (nsamp == N) begin
      check("start_hi", oSTART, 1);
      check("s_ready_drop", oS_READY, 0);
      check("busy_start", oBUSY, 1);
      for (int j = 0; j < N; j++) begin
`ifdef FHT_STREAM_BITREV_EN
        n = bitrev4(j);
`else
        n = j;
`endif
        exp_q.push_back(smp[n]);
      end
      iS_VALID = 1'b1;
      tick();
      check("start_once", start_cnt - s0, 1);
      check("start_lo", oSTART, 0);
      check("we_ignored", oWE, 0);
      check("s_ready_wait", oS_READY, 0);
      iS_VALID = 1'b0;
    end
  endtask

  task automatic wait_rdy(input int idle, input bit held);
    repeat (idle) tick();
    check("no_early_read", oM_VALID, 0);
    check("busy_wait", oBUSY, 1);
    if (held) begin
      check("rd_addr_hold", oADDR_RD_1, 3);
      iRDY = 1'b0;
      tick();
    end
    iRDY = 1'b1;
    tick();
    iRDY = 1'b0;
    check("rd_addr0", oADDR_RD_0, 0);
    check("rd_addr2", oADDR_RD_2, 0);
  endtask

  task automatic recv(input bit rnd);
    int got = 0, cyc = 0, first = -1, last_cyc = 0;
    bit held = 0;
    logic [D-1:0] hd, exp;
    logic hl;
    while (got < N && cyc < 400) begin
      iM_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (oM_VALID) begin
        if (first < 0) begin
          first = cyc;
          check("read_latency", first, 2);
        end
        if (held) begin
          check("stall_data", oM_DATA, hd);
          check("stall_last", oM_LAST, hl);
        end
        if (iM_READY) begin
          check("q_nonempty", exp_q.size() != 0, 1);
          exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
          check("m_data", oM_DATA, exp);
          check("m_last", oM_LAST, got == N - 1);
          got++;
          held = 0;
          last_cyc = cyc;
        end else begin
          held = 1;
          hd = oM_DATA;
          hl = oM_LAST;
        end
      end
      tick();
      cyc++;
    end
    iM_READY = 1'b0;
    check("recv_count", got, N);
    if (!rnd) check("throughput", last_cyc - first + 1, THR_CYC);
    check("back_to_load", oS_READY, 1);
    check("idle_busy", oBUSY, 0);
    check("valid_drop", oM_VALID, 0);
  endtask

  initial begin
    iRESET   = 1'b0;
    iS_VALID = 1'b0;
    iS_DATA  = '0;
    iM_READY = 1'b0;
    iRDY     = 1'b0;
    repeat (3) tick();
    check("rst_s_ready", oS_READY, 1);
    check("rst_we", oWE, 0);
    check("rst_start", oSTART, 0);
    check("rst_m_valid", oM_VALID, 0);
    check("rst_m_last", oM_LAST, 0);
    check("rst_busy", oBUSY, 0);
    iRESET = 1'b1;
    tick();

    load_frame(N, 16'h0100, 1'b1);
    wait_rdy(20, 1'b0);
    recv(1'b0);

    iRDY = 1'b1;
    load_frame(N, 16'hA000, 1'b0);
    wait_rdy(10, 1'b1);
    recv(1'b1);

    load_frame(7, 16'h3300, 1'b0);
    iRESET = 1'b0;
    #1;
    check("mid_rst_we", oWE, 0);
    check("mid_rst_s_ready", oS_READY, 1);
    check("mid_rst_busy", oBUSY, 0);
    tick();
    check("mid_rst_we_next", oWE, 0);
    check("mid_rst_start", oSTART, 0);
    iRESET = 1'b1;
    tick();
    load_frame(N, 16'h5A00, 1'b0);
    wait_rdy(3, 1'b0);
    recv(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
